hazard_stall_ctrl: RTL and testbench

//  Drives the stall/flush controls of PC, IF_ID, ID_EX and EX_MEM. Detects load-use hazards
//  (ID reads reg loaded by EX) and holds EX for multi-cycle ops (MULTI_LAT cycles),

---
 rtl/hazard_stall_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Stall/flush sequencer for PC, IF_ID, ID_EX and EX_MEM.
//                Detects load-use hazards and holds EX for MULTI_LAT cycles
//                while a multi-cycle op runs, inserting bubbles into EX_MEM.
//                It also sequences taken-branch flushes and defers any flush
//                that arrives while EX is held until the op releases.
//                Optional macro HAZ_STALL_CNT_EN adds the stall_cycles
//                counter port.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MULTI_LAT = 4,   // total EX occupancy of a multi-cycle op, 2..16
    parameter int CNT_W     = 32   // stall_cycles width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_multi,
    input  logic             flush_req,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             ex_busy
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam int CW = ($clog2(MULTI_LAT) < 1) ? 1 : $clog2(MULTI_LAT);
    // Entry cycle (in RUN) and release cycle (cnt==0) are not counted.
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULTI_LAT - 2);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_flush_q, pend_flush_d;
    logic            load_use;

    // Load in EX whose destination is a register the ID instruction reads.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

    // Next state and control outputs; everything forced low during reset.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_flush_d = pend_flush_q;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        ex_busy      = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_multi) begin
                    // A multi op that is also a load is handled purely as multi.
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    cnt_d        = CNT_LOAD;
                    pend_flush_d = flush_req;
                    state_d      = MULTI;
                end else if (flush_req) begin
                    // Flushed ID instruction makes any load-use moot.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            MULTI: begin
                ex_busy = 1'b1;
                if (cnt_q != '0) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_flush = 1'b1;
                    cnt_d        = cnt_q - CW'(1);
                    pend_flush_d = pend_flush_q | flush_req;
                end else begin
                    // Release: result moves to EX_MEM, deferred flush applied now.
                    if (pend_flush_q || flush_req) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                    pend_flush_d = 1'b0;
                    state_d      = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (reset) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            ex_busy      = 1'b0;
        end
    end

    // State, occupancy counter and deferred-flush flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_flush_q <= pend_flush_d;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Directed, table-driven bench for hazard_stall_ctrl
//                (MULTI_LAT=4). Output vector order:
//                {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
//                 id_ex_flush, ex_mem_flush, ex_busy}
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, ex_memread, ex_multi, flush_req;
    logic       pc_stall, if_id_stall, id_ex_stall;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, ex_busy;
`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_stall_ctrl #(.MULTI_LAT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .ex_multi     (ex_multi),
        .flush_req    (flush_req),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .id_ex_stall  (id_ex_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .ex_busy      (ex_busy)
`ifdef HAZ_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    logic [6:0] w_out;
    assign w_out = {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
                    id_ex_flush, ex_mem_flush, ex_busy};

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [4:0] ert;
        logic       fl;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [6:0] exp);
        checks++;
        if (w_out !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, w_out, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_in();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_multi = 1'b0; flush_req = 1'b0;
    endtask

    task automatic set_lu();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    endtask

    initial begin
        //            rs     rt     urs  urt  mr   ert    fl   expected
        vecs[0] = '{5'd5,  5'd0,  1'b1,1'b0,1'b1,5'd5,  1'b0,7'b1100100}; // rs load-use
        vecs[1] = '{5'd0,  5'd0,  1'b1,1'b0,1'b1,5'd0,  1'b0,7'b0000000}; // ex_rt = r0
        vecs[2] = '{5'd5,  5'd0,  1'b0,1'b0,1'b1,5'd5,  1'b0,7'b0000000}; // rs not read
        vecs[3] = '{5'd1,  5'd9,  1'b0,1'b1,1'b1,5'd9,  1'b0,7'b1100100}; // rt load-use
        vecs[4] = '{5'd1,  5'd9,  1'b0,1'b0,1'b1,5'd9,  1'b0,7'b0000000}; // rt not read
        vecs[5] = '{5'd5,  5'd0,  1'b1,1'b0,1'b0,5'd5,  1'b0,7'b0000000}; // not a load
        vecs[6] = '{5'd5,  5'd0,  1'b1,1'b0,1'b1,5'd5,  1'b1,7'b0001100}; // flush beats load-use
        vecs[7] = '{5'd3,  5'd4,  1'b1,1'b1,1'b0,5'd0,  1'b1,7'b0001100}; // flush alone
        vecs[8] = '{5'd31, 5'd31, 1'b1,1'b1,1'b1,5'd31, 1'b0,7'b1100100}; // r31 on both
        vecs[9] = '{5'd6,  5'd7,  1'b1,1'b1,1'b1,5'd5,  1'b0,7'b0000000}; // no match

        clr_in();
        set_lu();
        reset = 1'b1;
        #2;
        chk("reset_forces_zero", 7'b0000000);
        cyc();
        reset = 1'b0;
        clr_in();
        #2;
        chk("idle_after_reset", 7'b0000000);

        // RUN-state combinational vectors
        for (int i = 0; i < 10; i++) begin
            cyc();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
            ex_memread = vecs[i].mr; ex_rt = vecs[i].ert;
            flush_req = vecs[i].fl; ex_multi = 1'b0;
            #2;
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load-use lasts one cycle once the load moves on
        cyc(); clr_in(); set_lu(); #2; chk("lu_cycle", 7'b1100100);
        cyc(); clr_in(); #2;           chk("lu_gone",  7'b0000000);

        // Multi op held, back-to-back, load-use ignored while busy
        cyc(); ex_multi = 1'b1; #2; chk("mA_c1", 7'b1110010);
        cyc(); #2;                  chk("mA_c2", 7'b1110011);
        cyc(); #2;                  chk("mA_c3", 7'b1110011);
        cyc(); #2;                  chk("mA_rel", 7'b0000001);
        cyc(); #2;                  chk("mA_b2b", 7'b1110010);
        cyc(); ex_multi = 1'b0; set_lu(); #2; chk("mA_lu_ign", 7'b1110011);
        cyc(); #2;                  chk("mA_c7", 7'b1110011);
        cyc(); #2;                  chk("mA_rel2_lu", 7'b0000001);
        cyc(); #2;                  chk("mA_run_lu", 7'b1100100);
        cyc(); clr_in(); #2;        chk("mA_idle", 7'b0000000);

        // Flush pulsed in cycle 2 of a multi op is deferred to release
        cyc(); ex_multi = 1'b1; #2; chk("mB_c1", 7'b1110010);
        cyc(); ex_multi = 1'b0; flush_req = 1'b1; #2; chk("mB_c2", 7'b1110011);
        cyc(); flush_req = 1'b0; #2; chk("mB_c3", 7'b1110011);
        cyc(); #2;                   chk("mB_rel_flush", 7'b0001101);
        cyc(); #2;                   chk("mB_idle", 7'b0000000);

        // Flush at op entry is remembered
        cyc(); ex_multi = 1'b1; flush_req = 1'b1; #2; chk("mC_c1", 7'b1110010);
        cyc(); clr_in(); #2;         chk("mC_c2", 7'b1110011);
        cyc(); #2;                   chk("mC_c3", 7'b1110011);
        cyc(); #2;                   chk("mC_rel_flush", 7'b0001101);
        cyc(); #2;                   chk("mC_no_repeat", 7'b0000000);

        // Reset asserted in cycle 2 of a multi op
        cyc(); ex_multi = 1'b1; #2; chk("mD_c1", 7'b1110010);
        cyc(); ex_multi = 1'b0; #2; chk("mD_c2", 7'b1110011);
        #1; reset = 1'b1; #1;
        chk("mD_reset_now", 7'b0000000);
`ifdef HAZ_STALL_CNT_EN
        checks++;
        if (stall_cycles !== 32'd0) begin
            failures++;
            $display("FAIL cnt_reset: got %0d expected 0", stall_cycles);
        end
`endif
        cyc(); reset = 1'b0; #2; chk("mD_run_after", 7'b0000000);
        cyc(); #2;               chk("mD_still_idle", 7'b0000000);

`ifdef HAZ_STALL_CNT_EN
        // One multi op (3 stall cycles) plus one load-use cycle
        cyc(); ex_multi = 1'b1; #2;
        cyc(); ex_multi = 1'b0; #2;
        cyc(); cyc(); cyc(); set_lu(); #2;
        cyc(); clr_in(); #2;
        checks++;
        if (stall_cycles !== 32'd4) begin
            failures++;
            $display("FAIL cnt_value: got %0d expected 4", stall_cycles);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
